qif_neuron_array: RTL and testbench

- Parametrised, time-multiplexed array of quadratic integrate-and-fire (QIF) neurons. Successor to the single 8-bit QIF core.
- One shared update datapath serves N_CH channels round-robin, one channel per enabled clock cycle. One "step" is N_CH enabled cycles.
- Adds configurable width, channel count, leak and refractory period, plus per-channel state readback. Sits behind the tt_um top-level pin wrapper.

---
 rtl/qif_neuron_array.sv | 185 ++++++++++++++++++
 tb/tb_qif_neuron_array.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qif_neuron_array.sv
// Time-multiplexed array of quadratic integrate-and-fire neurons sharing one update datapath.
// Optional per-channel saturating spike counters are enabled by defining QIF_SPIKE_COUNT_EN.
module qif_neuron_array #(
  parameter int WIDTH    = 8,
  parameter int N_CH     = 4,
  parameter int SQ_SHIFT = 8,
  parameter int LEAK     = 1,
  parameter int THRESH   = 200,
  parameter int V_RESET  = 0,
  parameter int REFRAC   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_CH*WIDTH-1:0]     cur_in,
  input  logic [$clog2(N_CH)-1:0]   rd_sel,
  output logic [N_CH-1:0]           spike,
  output logic                      step_done,
  output logic [$clog2(N_CH)-1:0]   ch_idx,
  output logic [WIDTH-1:0]          v_out
`ifdef QIF_SPIKE_COUNT_EN
  ,
  input  logic                      clr_cnt,
  output logic [7:0]                cnt_out
`endif
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int SUM_W = 2*WIDTH + 2;
  localparam int RW    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic [IDX_W-1:0]        LAST_CH   = IDX_W'(N_CH - 1);
  localparam logic [WIDTH-1:0]        V_RST     = WIDTH'(V_RESET);
  localparam logic [RW-1:0]           REFRAC_LD = RW'(REFRAC);
  localparam logic signed [SUM_W-1:0] LEAK_S    = SUM_W'(LEAK);
  localparam logic signed [SUM_W-1:0] THRESH_S  = SUM_W'(THRESH);
  localparam logic signed [SUM_W-1:0] V_MAX_S   = SUM_W'((2**WIDTH) - 1);

  logic [WIDTH-1:0] v_q  [N_CH];
  logic [WIDTH-1:0] v_d  [N_CH];
  logic [RW-1:0]    rf_q [N_CH];
  logic [RW-1:0]    rf_d [N_CH];
  logic [N_CH-1:0]  spike_q, spike_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             step_done_q, step_done_d;

  logic [WIDTH-1:0]          v_sel, i_sel;
  logic [RW-1:0]             rf_sel;
  logic [2*WIDTH-1:0]        sq_full, sq_shr;
  logic signed [SUM_W-1:0]   sum_s;
  logic                      fire;

  // Clamp an unbounded signed sum into the unsigned membrane range.
  function automatic logic [WIDTH-1:0] sat_v(input logic signed [SUM_W-1:0] x);
    if (x < 0)
      return '0;
    else if (x > V_MAX_S)
      return '1;
    else
      return x[WIDTH-1:0];
  endfunction

  always_comb begin
    v_sel  = '0;
    i_sel  = '0;
    rf_sel = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ptr_q == IDX_W'(c)) begin
        v_sel  = v_q[c];
        i_sel  = cur_in[c*WIDTH +: WIDTH];
        rf_sel = rf_q[c];
      end
    end
  end

  // Shared datapath: all terms zero-extended so the signed sum never overflows.
  assign sq_full = {{WIDTH{1'b0}}, v_sel} * {{WIDTH{1'b0}}, v_sel};
  assign sq_shr  = sq_full >> SQ_SHIFT;
  assign sum_s   = $signed({{(SUM_W-WIDTH){1'b0}}, v_sel})
                 + $signed({2'b00, sq_shr})
                 + $signed({{(SUM_W-WIDTH){1'b0}}, i_sel})
                 - LEAK_S;
  assign fire    = (sum_s >= THRESH_S);

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      v_d[c]  = v_q[c];
      rf_d[c] = rf_q[c];
    end
    spike_d     = spike_q;
    ptr_d       = ptr_q;
    step_done_d = step_done_q;
    if (en) begin
      ptr_d       = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
      step_done_d = (ptr_q == LAST_CH);
      for (int c = 0; c < N_CH; c++) begin
        if (ptr_q == IDX_W'(c)) begin
          if (rf_sel != '0) begin
            rf_d[c]    = rf_sel - 1'b1;
            v_d[c]     = V_RST;
            spike_d[c] = 1'b0;
          end else if (fire) begin
            rf_d[c]    = REFRAC_LD;
            v_d[c]     = V_RST;
            spike_d[c] = 1'b1;
          end else begin
            v_d[c]     = sat_v(sum_s);
            spike_d[c] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        v_q[c]  <= V_RST;
        rf_q[c] <= '0;
      end
      spike_q     <= '0;
      ptr_q       <= '0;
      step_done_q <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        v_q[c]  <= v_d[c];
        rf_q[c] <= rf_d[c];
      end
      spike_q     <= spike_d;
      ptr_q       <= ptr_d;
      step_done_q <= step_done_d;
    end
  end

  assign spike     = spike_q;
  assign step_done = step_done_q;
  assign ch_idx    = ptr_q;

  // Out-of-range selects fall through to zero.
  always_comb begin
    v_out = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rd_sel == IDX_W'(c))
        v_out = v_q[c];
    end
  end

`ifdef QIF_SPIKE_COUNT_EN
  logic [7:0] cnt_q [N_CH];
  logic [7:0] cnt_d [N_CH];
  logic       fire_upd;

  assign fire_upd = en && (rf_sel == '0) && fire;

  // Clear wins over a same-cycle increment.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (fire_upd && (ptr_q == IDX_W'(c)) && (cnt_q[c] != 8'hFF))
        cnt_d[c] = cnt_q[c] + 8'd1;
      if (clr_cnt)
        cnt_d[c] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++)
        cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        cnt_q[c] <= cnt_d[c];
    end
  end

  always_comb begin
    cnt_out = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rd_sel == IDX_W'(c))
        cnt_out = cnt_q[c];
    end
  end
`endif

endmodule

// File: tb/tb_qif_neuron_array.sv
// Self-checking bench for qif_neuron_array: hand tables, corner sequences and a
// randomized run against an arithmetic reference model (QIF_SPIKE_COUNT_EN aware).
module tb_qif_neuron_array;
  localparam int N        = 4;
  localparam int W        = 8;
  localparam int THRESH   = 200;
  localparam int LEAK     = 1;
  localparam int REFRAC   = 2;
  localparam int VMAX     = 255;
  localparam int SQ_DIV   = 256;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en  = 1'b0;
  logic [N*W-1:0] cur_in = '0;
  logic [1:0]     rd_sel = '0;
  logic [N-1:0]   spike;
  logic           step_done;
  logic [1:0]     ch_idx;
  logic [W-1:0]   v_out;

  logic [3*W-1:0] cur3 = {8'd60, 8'd60, 8'd60};
  logic [1:0]     rd3 = '0;
  logic [2:0]     spike3;
  logic           sd3;
  logic [1:0]     idx3;
  logic [W-1:0]   v3;

`ifdef QIF_SPIKE_COUNT_EN
  logic           clr_cnt = 1'b0;
  logic [7:0]     cnt_out;
  logic [7:0]     cnt_out3;
`endif

  always #10 clk = ~clk;

  qif_neuron_array u_dut (
    .clk(clk), .rst(rst), .en(en), .cur_in(cur_in), .rd_sel(rd_sel),
    .spike(spike), .step_done(step_done), .ch_idx(ch_idx), .v_out(v_out)
`ifdef QIF_SPIKE_COUNT_EN
    , .clr_cnt(clr_cnt), .cnt_out(cnt_out)
`endif
  );

  qif_neuron_array #(.N_CH(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .cur_in(cur3), .rd_sel(rd3),
    .spike(spike3), .step_done(sd3), .ch_idx(idx3), .v_out(v3)
`ifdef QIF_SPIKE_COUNT_EN
    , .clr_cnt(clr_cnt), .cnt_out(cnt_out3)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int           m_v   [N];
  int           m_r   [N];
  int           m_cnt [N];
  logic [N-1:0] m_spk = '0;
  int           m_ptr = 0;
  logic         m_sd  = 1'b0;

  typedef struct {
    logic [7:0] cur1;
    int         step;
    int         exp_v;
    logic       exp_spk;
  } vec_t;
  vec_t tbl [6];

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endfunction

  task automatic model_edge();
    int c, i, sum;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_v[k] = 0; m_r[k] = 0; m_cnt[k] = 0;
      end
      m_spk = '0; m_ptr = 0; m_sd = 1'b0;
    end else begin
      if (en) begin
        c = m_ptr;
        i = int'(cur_in[c*W +: W]);
        if (m_r[c] > 0) begin
          m_r[c]   = m_r[c] - 1;
          m_v[c]   = 0;
          m_spk[c] = 1'b0;
        end else begin
          sum = m_v[c] + (m_v[c] * m_v[c]) / SQ_DIV + i - LEAK;
          if (sum >= THRESH) begin
            m_spk[c] = 1'b1;
            m_v[c]   = 0;
            m_r[c]   = REFRAC;
            if (m_cnt[c] < 255) m_cnt[c] = m_cnt[c] + 1;
          end else begin
            m_spk[c] = 1'b0;
            m_v[c]   = (sum < 0) ? 0 : ((sum > VMAX) ? VMAX : sum);
          end
        end
        m_sd  = (c == N-1);
        m_ptr = (m_ptr + 1) % N;
      end
`ifdef QIF_SPIKE_COUNT_EN
      if (clr_cnt)
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
`endif
    end
  endtask

  task automatic check_state();
    chk("ch_idx", int'(ch_idx), m_ptr);
    chk("spike", int'(spike), int'(m_spk));
    chk("step_done", int'(step_done), int'(m_sd));
    for (int c = 0; c < N; c++) begin
      rd_sel = 2'(c);
      #1;
      chk($sformatf("v_out[%0d]", c), int'(v_out), m_v[c]);
`ifdef QIF_SPIKE_COUNT_EN
      chk($sformatf("cnt_out[%0d]", c), int'(cnt_out), m_cnt[c]);
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_table(string tag);
    int hi;
    hi = 0;
    en = 1'b1;
    cur_in = '0;
    for (int k = 0; k < 6; k++) begin
      cur_in[15:8] = tbl[k].cur1;
      repeat (4) begin
        tick();
        if (spike[1]) hi++;
      end
      rd_sel = 2'd1;
      #1;
      chk($sformatf("%s.v1_step%0d", tag, tbl[k].step), int'(v_out), tbl[k].exp_v);
      chk($sformatf("%s.spk1_step%0d", tag, tbl[k].step), int'(spike[1]), int'(tbl[k].exp_spk));
    end
    chk({tag, ".spk1_width"}, hi, 4);
    chk({tag, ".other_spk"}, int'({spike[3:2], spike[0]}), 0);
    for (int c = 0; c < N; c++) begin
      if (c != 1) begin
        rd_sel = 2'(c);
        #1;
        chk($sformatf("%s.other_v%0d", tag, c), int'(v_out), 0);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    tbl[0] = '{8'd50, 1, 49,  1'b0};
    tbl[1] = '{8'd50, 2, 107, 1'b0};
    tbl[2] = '{8'd50, 3, 0,   1'b1};
    tbl[3] = '{8'd50, 4, 0,   1'b0};
    tbl[4] = '{8'd50, 5, 0,   1'b0};
    tbl[5] = '{8'd50, 6, 49,  1'b0};
    for (int k = 0; k < N; k++) begin
      m_v[k] = 0; m_r[k] = 0; m_cnt[k] = 0;
    end

    // Reset state
    do_reset();
    chk("rst.idx", int'(ch_idx), 0);
    chk("rst.spike", int'(spike), 0);
    chk("rst.sd", int'(step_done), 0);

    // Basic QIF trajectory on channel 1
    run_table("t1");

    // Large current spikes from rest; zero current clamps at zero
    do_reset();
    cur_in = '0;
    cur_in[7:0] = 8'd255;
    en = 1'b1;
    tick();
    chk("t2.spk0", int'(spike[0]), 1);
    rd_sel = 2'd0; #1;
    chk("t2.v0", int'(v_out), 0);
    repeat (3) tick();
    rd_sel = 2'd2; #1;
    chk("t2.v2_clamp", int'(v_out), 0);
    chk("t2.sd", int'(step_done), 1);
    chk("t2.spk0_hold", int'(spike[0]), 1);

    // Enable stall mid-step delays step_done by the stall length
    do_reset();
    cur_in = {8'd30, 8'd20, 8'd10, 8'd5};
    en = 1'b1;
    tick(); tick();
    cnt = 2;
    en = 1'b0;
    repeat (5) begin
      tick();
      cnt++;
      chk("t3.frz_idx", int'(ch_idx), 2);
      chk("t3.frz_sd", int'(step_done), 0);
    end
    en = 1'b1;
    while (!step_done && cnt < 30) begin
      tick();
      cnt++;
    end
    chk("t3.sd_delay", cnt, 9);

    // Reset mid-step discards the partial step
    do_reset();
    cur_in = '0;
    cur_in[15:8] = 8'd50;
    en = 1'b1;
    repeat (6) tick();
    rd_sel = 2'd1; #1;
    chk("t4.pre_idx", int'(ch_idx), 2);
    chk("t4.pre_v1", int'(v_out), 107);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4.idx", int'(ch_idx), 0);
    chk("t4.spike", int'(spike), 0);
    chk("t4.sd", int'(step_done), 0);
    for (int c = 0; c < N; c++) begin
      rd_sel = 2'(c); #1;
      chk($sformatf("t4.v%0d", c), int'(v_out), 0);
    end
    run_table("t4");

    // Non-power-of-two channel count: wrap and out-of-range readback
    do_reset();
    en = 1'b1;
    repeat (3) tick();
    chk("t5.idx3_wrap", int'(idx3), 0);
    chk("t5.sd3", int'(sd3), 1);
    rd3 = 2'd2; #1;
    chk("t5.v3_ch2", int'(v3), 59);
    rd3 = 2'd3; #1;
    chk("t5.v3_oor", int'(v3), 0);

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 79) == 0);
      for (int c = 0; c < N; c++)
        cur_in[c*W +: W] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 60));
      tick();
    end
    rst = 1'b0;

`ifdef QIF_SPIKE_COUNT_EN
    // Counter saturation and clear-over-increment
    do_reset();
    cur_in = '0;
    cur_in[7:0] = 8'd255;
    en = 1'b1;
    repeat (800 * N) tick();
    rd_sel = 2'd0; #1;
    chk("t7.cnt_sat", int'(cnt_out), 255);
    cnt = 0;
    while (!(m_ptr == 0 && m_r[0] == 0) && cnt < 12) begin
      tick();
      cnt++;
    end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("t7.clr_spk0", int'(spike[0]), 1);
    rd_sel = 2'd0; #1;
    chk("t7.clr_cnt", int'(cnt_out), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
